// File: rtl/food_pkg.sv
// Shared types and constants for the vending customer-side front end.
package food_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CREDIT,
    REQUEST,
    WAIT_RESP,
    REFUND,
    DONE
  } state_e;

  // Coin denomination codes as presented on coin_value.
  typedef enum logic [1:0] {
    COIN_1   = 2'd0,
    COIN_2   = 2'd1,
    COIN_4   = 2'd2,
    COIN_BAD = 2'd3
  } coin_e;

  localparam logic [2:0] ITEM_NONE  = 3'd0;
  localparam logic [2:0] MAX_CREDIT = 3'd7;

  // Credit units carried by a coin code; the illegal code carries none.
  function automatic logic [2:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_1:  return 3'd1;
      COIN_2:  return 3'd2;
      COIN_4:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_accum.sv
// Saturating 3-bit credit accumulator. A coin is added only when enabled,
// legal and the total stays within MAX_CREDIT; any other coin is returned
// with a one-cycle reject pulse.
module coin_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_value_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [2:0] credit_o,
  output logic       accept_o,
  output logic       reject_o
);
  import food_pkg::*;

  logic [2:0] credit_q, credit_d;
  logic       reject_q, reject_d;
  logic [3:0] sum;
  logic       legal;

  // Decide whether the offered coin fits and compute next credit.
  always_comb begin
    legal    = (coin_value_i != COIN_BAD);
    sum      = {1'b0, credit_q} + {1'b0, coin_units(coin_value_i)};
    accept_o = coin_valid_i && en_i && legal && (sum <= {1'b0, MAX_CREDIT});
    credit_d = credit_q;
    if (clr_i)
      credit_d = 3'd0;
    else if (accept_o)
      credit_d = sum[2:0];
    reject_d = coin_valid_i && !accept_o;
  end

  // Credit and reject pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= 3'd0;
      reject_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign credit_o = credit_q;
  assign reject_o = reject_q;

endmodule

// File: rtl/order_panel.sv
// Customer-side front end: gathers coins, latches a selection, presents it
// to the seller for a fixed hold window, then waits for the seller's answer
// (dispense, sold out or timeout) and reports dispense/change/refund pulses.
module order_panel #(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       select_valid,
  input  logic [2:0] select_code,
  input  logic       cancel,
  output logic [2:0] choice,
  output logic [2:0] money,
  input  logic [2:0] item,
  input  logic [2:0] available_item,
  input  logic [2:0] remaining_money,
  output logic       dispense_valid,
  output logic [2:0] dispensed_item,
  output logic       change_valid,
  output logic [2:0] change_out,
  output logic       coin_reject,
  output logic       err,
  output logic       busy
);
  import food_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       choice_q, money_q, disp_item_q, change_q;
  logic             disp_vld_q, change_vld_q, err_q;

  logic [2:0] credit;
  logic       coin_ok;
  logic       sel_ok, cancel_ok, acc_en, acc_clr;

  // Qualify keypad strobes; coins are only taken while credit is open and
  // nothing else is being acted on in the same cycle.
  always_comb begin
    sel_ok    = (state_q == CREDIT) && select_valid && (select_code != ITEM_NONE);
    cancel_ok = (state_q == CREDIT) && cancel;
    acc_en    = (state_q == IDLE) || ((state_q == CREDIT) && !sel_ok && !cancel_ok);
    acc_clr   = (state_q == REFUND) || (state_q == DONE);
  end

  coin_accum u_coin_accum (
    .clk          (clk),
    .rst          (rst),
    .coin_valid_i (coin_valid),
    .coin_value_i (coin_value),
    .en_i         (acc_en),
    .clr_i        (acc_clr),
    .credit_o     (credit),
    .accept_o     (coin_ok),
    .reject_o     (coin_reject)
  );

  // Transaction FSM with shared hold/timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      choice_q     <= ITEM_NONE;
      money_q      <= 3'd0;
      disp_vld_q   <= 1'b0;
      disp_item_q  <= ITEM_NONE;
      change_vld_q <= 1'b0;
      change_q     <= 3'd0;
      err_q        <= 1'b0;
    end else begin
      disp_vld_q   <= 1'b0;
      disp_item_q  <= ITEM_NONE;
      change_vld_q <= 1'b0;
      change_q     <= 3'd0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coin_ok)
            state_q <= CREDIT;
        end
        CREDIT: begin
          if (cancel_ok) begin
            state_q <= REFUND;
          end else if (sel_ok) begin
            choice_q <= select_code;
            money_q  <= credit;
            cnt_q    <= '0;
            state_q  <= REQUEST;
          end
        end
        REQUEST: begin
          if (cnt_q == HOLD_LAST) begin
            choice_q <= ITEM_NONE;
            money_q  <= 3'd0;
            cnt_q    <= '0;
            state_q  <= WAIT_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_RESP: begin
          if (item != ITEM_NONE) begin
            disp_vld_q   <= 1'b1;
            disp_item_q  <= item;
            change_vld_q <= 1'b1;
            change_q     <= remaining_money;
            state_q      <= DONE;
          end else if (((cnt_q == '0) && (available_item == ITEM_NONE)) ||
                       (cnt_q == TO_LAST)) begin
            err_q   <= 1'b1;
            state_q <= REFUND;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        REFUND: begin
          change_vld_q <= 1'b1;
          change_q     <= credit;
          state_q      <= IDLE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign choice         = choice_q;
  assign money          = money_q;
  assign dispense_valid = disp_vld_q;
  assign dispensed_item = disp_item_q;
  assign change_valid   = change_vld_q;
  assign change_out     = change_q;
  assign err            = err_q;
  assign busy           = !((state_q == IDLE) || (state_q == CREDIT));

endmodule

// File: tb/tb_order_panel.sv
// Directed bench for order_panel: one task per scenario, inline checks.
module tb_order_panel;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       select_valid;
  logic [2:0] select_code;
  logic       cancel;
  logic [2:0] choice;
  logic [2:0] money;
  logic [2:0] item;
  logic [2:0] available_item;
  logic [2:0] remaining_money;
  logic       dispense_valid;
  logic [2:0] dispensed_item;
  logic       change_valid;
  logic [2:0] change_out;
  logic       coin_reject;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [16:0] outs;
  assign outs = {choice, money, dispense_valid, dispensed_item, change_valid,
                 change_out, coin_reject, err, busy};

  order_panel dut (
    .clk             (clk),
    .rst             (rst),
    .coin_valid      (coin_valid),
    .coin_value      (coin_value),
    .select_valid    (select_valid),
    .select_code     (select_code),
    .cancel          (cancel),
    .choice          (choice),
    .money           (money),
    .item            (item),
    .available_item  (available_item),
    .remaining_money (remaining_money),
    .dispense_valid  (dispense_valid),
    .dispensed_item  (dispensed_item),
    .change_valid    (change_valid),
    .change_out      (change_out),
    .coin_reject     (coin_reject),
    .err             (err),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = 2'd0;
  endtask

  task automatic do_select(input logic [2:0] code);
    select_valid = 1'b1;
    select_code  = code;
    tick();
    select_valid = 1'b0;
    select_code  = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (outs !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== 17'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected 0", outs);
    end
  endtask

  task automatic test_purchase();
    available_item = 3'd2;
    put_coin(2'd2);
    put_coin(2'd1);
    checks++;
    if (coin_reject !== 1'b0) begin
      errors++;
      $display("FAIL purchase_coin_accept: coin_reject got %b expected 0", coin_reject);
    end
    do_select(3'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({choice, money, busy} !== {3'd3, 3'd6, 1'b1}) begin
        errors++;
        $display("FAIL purchase_hold[%0d]: choice/money/busy got %0d/%0d/%b expected 3/6/1",
                 i, choice, money, busy);
      end
      tick();
    end
    checks++;
    if ({choice, money, busy} !== {3'd0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL purchase_wait_clear: choice/money/busy got %0d/%0d/%b expected 0/0/1",
               choice, money, busy);
    end
    repeat (4) tick();
    item = 3'd3;
    remaining_money = 3'd1;
    tick();
    checks++;
    if ({dispense_valid, dispensed_item, change_valid, change_out, err} !==
        {1'b1, 3'd3, 1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL purchase_dispense: dv/di/cv/co/err got %b/%0d/%b/%0d/%b expected 1/3/1/1/0",
               dispense_valid, dispensed_item, change_valid, change_out, err);
    end
    item = 3'd0;
    remaining_money = 3'd0;
    tick();
    checks++;
    if (outs !== 17'd0) begin
      errors++;
      $display("FAIL purchase_back_idle: got %h expected 0", outs);
    end
  endtask

  task automatic test_coin_reject();
    put_coin(2'd2);
    checks++;
    if (coin_reject !== 1'b0) begin
      errors++;
      $display("FAIL reject_first4: coin_reject got %b expected 0", coin_reject);
    end
    put_coin(2'd2);
    checks++;
    if (coin_reject !== 1'b1) begin
      errors++;
      $display("FAIL reject_overflow: coin_reject got %b expected 1", coin_reject);
    end
    put_coin(2'd3);
    checks++;
    if (coin_reject !== 1'b1) begin
      errors++;
      $display("FAIL reject_illegal: coin_reject got %b expected 1", coin_reject);
    end
    do_select(3'd0);
    checks++;
    if ({coin_reject, busy, choice} !== {1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reject_select_zero: rej/busy/choice got %b/%b/%0d expected 0/0/0",
               coin_reject, busy, choice);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    checks++;
    if ({change_valid, change_out} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL reject_credit_kept: cv/co got %b/%0d expected 1/4", change_valid, change_out);
    end
    tick();
    checks++;
    if (outs !== 17'd0) begin
      errors++;
      $display("FAIL reject_pulse_end: got %h expected 0", outs);
    end
  endtask

  task automatic test_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    checks++;
    if ({change_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL cancel_idle_ignored: cv/busy got %b/%b expected 0/0", change_valid, busy);
    end
    do_select(3'd5);
    checks++;
    if ({busy, choice} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL select_idle_ignored: busy/choice got %b/%0d expected 0/0", busy, choice);
    end
    put_coin(2'd0);
    put_coin(2'd1);
    cancel = 1'b1;
    select_valid = 1'b1;
    select_code = 3'd3;
    tick();
    cancel = 1'b0;
    select_valid = 1'b0;
    select_code = 3'd0;
    checks++;
    if ({choice, busy} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL cancel_priority: choice/busy got %0d/%b expected 0/1", choice, busy);
    end
    tick();
    checks++;
    if ({change_valid, change_out, dispense_valid} !== {1'b1, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL cancel_refund: cv/co/dv got %b/%0d/%b expected 1/3/0",
               change_valid, change_out, dispense_valid);
    end
    tick();
    checks++;
    if (outs !== 17'd0) begin
      errors++;
      $display("FAIL cancel_back_idle: got %h expected 0", outs);
    end
  endtask

  task automatic test_timeout();
    int n;
    available_item = 3'd1;
    put_coin(2'd2);
    put_coin(2'd0);
    do_select(3'd2);
    repeat (4) tick();
    checks++;
    if ({err, busy, choice} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL timeout_wait_entry: err/busy/choice got %b/%b/%0d expected 0/1/0",
               err, busy, choice);
    end
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (err === 1'b1) break;
    end
    checks++;
    if (n !== 200) begin
      errors++;
      $display("FAIL timeout_cycles: err after %0d cycles expected 200", n);
    end
    tick();
    checks++;
    if ({change_valid, change_out, err} !== {1'b1, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL timeout_refund: cv/co/err got %b/%0d/%b expected 1/5/0",
               change_valid, change_out, err);
    end
    tick();
  endtask

  task automatic test_sold_out();
    available_item = 3'd0;
    put_coin(2'd2);
    do_select(3'd1);
    repeat (4) tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL soldout_early_err: err got %b expected 0", err);
    end
    tick();
    checks++;
    if ({err, busy, change_valid} !== {1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL soldout_err: err/busy/cv got %b/%b/%b expected 1/1/0", err, busy, change_valid);
    end
    tick();
    checks++;
    if ({change_valid, change_out, err} !== {1'b1, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL soldout_refund: cv/co/err got %b/%0d/%b expected 1/4/0",
               change_valid, change_out, err);
    end
    tick();
    available_item = 3'd2;
  endtask

  task automatic test_select_coin();
    available_item = 3'd3;
    put_coin(2'd1);
    select_valid = 1'b1;
    select_code = 3'd6;
    coin_valid = 1'b1;
    coin_value = 2'd0;
    tick();
    select_valid = 1'b0;
    select_code = 3'd0;
    coin_valid = 1'b0;
    checks++;
    if ({coin_reject, choice, money} !== {1'b1, 3'd6, 3'd2}) begin
      errors++;
      $display("FAIL select_coin_same_cycle: rej/choice/money got %b/%0d/%0d expected 1/6/2",
               coin_reject, choice, money);
    end
    repeat (4) tick();
    item = 3'd6;
    remaining_money = 3'd0;
    tick();
    checks++;
    if ({dispense_valid, dispensed_item, change_valid, change_out} !==
        {1'b1, 3'd6, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL select_coin_dispense: dv/di/cv/co got %b/%0d/%b/%0d expected 1/6/1/0",
               dispense_valid, dispensed_item, change_valid, change_out);
    end
    item = 3'd0;
    tick();
  endtask

  task automatic test_async_reset();
    logic seen;
    available_item = 3'd1;
    put_coin(2'd1);
    do_select(3'd5);
    repeat (4) tick();
    repeat (2) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_busy: busy got %b expected 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== 17'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %h expected 0", outs);
    end
    item = 3'd4;
    remaining_money = 3'd2;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | dispense_valid | change_valid | err | coin_reject | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL areset_no_pulses: got %b expected 0", seen);
    end
    item = 3'd0;
    remaining_money = 3'd0;
    put_coin(2'd0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    checks++;
    if ({change_valid, change_out} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL areset_credit_discarded: cv/co got %b/%0d expected 1/1",
               change_valid, change_out);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    coin_valid = 1'b0;
    coin_value = 2'd0;
    select_valid = 1'b0;
    select_code = 3'd0;
    cancel = 1'b0;
    item = 3'd0;
    available_item = 3'd2;
    remaining_money = 3'd0;
    test_reset();
    test_purchase();
    test_coin_reject();
    test_cancel();
    test_timeout();
    test_sold_out();
    test_select_coin();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/order_panel.md
Name: order_panel

Overview:
- Customer-side front end for the vending controller. It accumulates coins, latches a selection and drives the seller's choice/money inputs.
- It consumes the seller's item / available_item / remaining_money outputs and presents dispense and change results to the user side.
- It sits between the coin/keypad inputs and the food_seller-facing interface at the top level.
- It is the initiator of the exchange the seller responds to.

Parameters:
- HOLD_CYCLES, 4: cycles choice/money are held stable toward the seller.
- TIMEOUT_CYCLES, 200: maximum WAIT_RESP cycles before a forced refund.
- CNT_W, 8: width of the shared hold/timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin-inserted strobe.
- coin_value  in  2  coin denomination: 0=1 unit, 1=2 units, 2=4 units, 3=illegal.
- select_valid  in  1  one-cycle selection strobe.
- select_code  in  3  requested item code; 0 = none.
- cancel  in  1  one-cycle refund request.
- choice  out  3  item code toward seller.
- money  out  3  credit toward seller.
- item  in  3  dispensed item from seller; 0 = none.
- available_item  in  3  seller stock of the requested item.
- remaining_money  in  3  change reported by seller.
- dispense_valid  out  1  one-cycle pulse; dispensed_item is valid.
- dispensed_item  out  3  captured item code.
- change_valid  out  1  one-cycle pulse; change_out is valid.
- change_out  out  3  change or refund amount.
- coin_reject  out  1  one-cycle pulse; coin returned.
- err  out  1  one-cycle pulse on sold-out or timeout.
- busy  out  1  high in any state other than IDLE or CREDIT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; credit, counter, latched choice all 0.
  - All outputs 0.
  - Reset mid-transaction discards credit with no refund pulse.
- States: IDLE, CREDIT, REQUEST, WAIT_RESP, REFUND, DONE.
- IDLE / CREDIT, coin_valid:
  - credit += value.
  - If the sum would exceed 7 or coin_value==3: credit unchanged and coin_reject pulses next cycle.
  - First accepted coin moves IDLE->CREDIT.
- CREDIT, select_valid with select_code!=0:
  - Latch choice=select_code and money=credit; go to REQUEST with counter=0.
  - A coin in the same cycle is rejected (coin_reject), not added.
  - select_code==0, or a select in IDLE, is ignored.
- CREDIT, cancel -> REFUND. Cancel has priority over select in the same cycle. Cancel in IDLE is ignored.
- REQUEST:
  - choice/money driven stable for exactly HOLD_CYCLES cycles.
  - Then both are driven to 0; counter cleared; go to WAIT_RESP.
  - coin, select and cancel are ignored; coins pulse coin_reject.
- WAIT_RESP:
  - item!=0: capture item and remaining_money; next cycle pulse dispense_valid and change_valid together (change_out = captured remaining_money, may be 0); go to DONE.
  - item==0 and available_item==0 on the first WAIT_RESP cycle: sold out. err pulses; go to REFUND.
  - counter reaches TIMEOUT_CYCLES-1 with no item: err pulses; go to REFUND.
  - cancel is ignored.
- REFUND:
  - change_out=credit, change_valid pulses for 1 cycle.
  - Credit cleared; go to IDLE.
- DONE: credit cleared; go to IDLE next cycle.
- Pulse rule: dispensed_item and change_out hold their value only during their valid pulse and are 0 otherwise.
- Latency: select accepted at cycle T -> choice valid T+1..T+HOLD_CYCLES.

Decomposition:
- Shared package (food_pkg):
  - state enum.
  - Coin value encoding and decode function.
  - ITEM_NONE=3'd0.
  - MAX_CREDIT=3'd7.
- Natural sub-module: coin_accum (saturating 3-bit credit accumulator with reject pulse).
- The FSM and counter stay in order_panel.

Test Plan:
- Coins 2,1 (values 4,2), select 3, seller returns item=3, remaining_money=1 after 5 cycles -> choice=3, money=6 for 4 cycles; then dispense_valid with dispensed_item=3 and change_valid with change_out=1 in the same cycle; return to IDLE.
- Coins 4,4 -> second coin rejected (coin_reject pulse), credit stays 4. Coin value code 3 -> rejected.
- Coins 1+2 (credit 3), then cancel -> change_valid with change_out=3; IDLE; no dispense_valid.
- Credit 5, select 2, seller never responds -> err after TIMEOUT_CYCLES in WAIT_RESP; change_out=5.
- Credit 4, select 1 with available_item=0, item=0 -> err on first WAIT_RESP cycle; refund 4.
- Assert rst low during WAIT_RESP -> all outputs 0 immediately (asynchronous); state IDLE; no pulses after release.
- Same-cycle select and coin in CREDIT -> coin rejected, money = prior credit.
